// File: rtl/muldiv_pkg.sv
// Shared types, decode constants and sign helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  function automatic logic [MD_XLEN-1:0] md_neg(input logic [MD_XLEN-1:0] v);
    return (~v) + MD_XLEN'(1);
  endfunction

  // Conditional two's-complement negate; doubles as |v| when neg is the sign bit.
  function automatic logic [MD_XLEN-1:0] md_cneg(input logic [MD_XLEN-1:0] v, input logic neg);
    return neg ? md_neg(v) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide unit for RV32M, holding the pipeline via stall_o.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [CW-1:0]     count_q, count_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   result_q, result_d;

  md_op_e            op_in;
  logic              s1, s2, is_rem_in, ovf_in;
  logic [2*XLEN-1:0] acc_nx, prod_fix;
  logic [XLEN:0]     rem_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_nx, quo_nx, mul_res, div_res;

  assign op_in     = md_op_e'(funct3_i);
  assign s1        = rs1_i[XLEN-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign s2        = rs2_i[XLEN-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
  assign is_rem_in = op_in inside {OP_REM, OP_REMU};
  assign ovf_in    = (op_in inside {OP_DIV, OP_REM}) &&
                     (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

  // One iteration of each datapath; the final iteration feeds the sign fix directly.
  assign acc_nx   = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign prod_fix = neg_q ? (~acc_nx) + (2*XLEN)'(1) : acc_nx;
  assign mul_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign ge      = rem_sh >= {1'b0, divisor_q};
  assign rem_nx  = ge ? XLEN'(rem_sh - {1'b0, divisor_q}) : rem_sh[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], ge};
  assign div_res = (op_q inside {OP_REM, OP_REMU}) ? md_cneg(rem_nx, rem_neg_q)
                                                  : md_cneg(quo_nx, neg_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          op_d      = op_in;
          neg_d     = s1 ^ s2;
          rem_neg_d = s1;
          if (funct3_i[2]) begin
            if (rs2_i == '0) begin
              result_d = is_rem_in ? rs1_i : '1;
              state_d  = DONE;
            end else if (ovf_in) begin
              result_d = is_rem_in ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              state_d  = DONE;
            end else begin
              quo_d     = md_cneg(rs1_i, s1);
              divisor_d = md_cneg(rs2_i, s2);
              rem_d     = '0;
              count_d   = CW'(XLEN);
              state_d   = DIV;
            end
          end else begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, md_cneg(rs1_i, s1)};
            mplier_d = md_cneg(rs2_i, s2);
            count_d  = CW'(XLEN);
            state_d  = MUL;
          end
        end
      end
      MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          result_d = mul_res;
          state_d  = DONE;
        end
      end
      DIV: begin
        rem_d   = rem_nx;
        quo_d   = quo_nx;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          result_d = div_res;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flushed instruction never writes back, so the previous result stays visible.
    if (flush_i) begin
      state_d  = IDLE;
      count_d  = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      count_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = (state_q == MUL) || (state_q == DIV);
  assign stall_o  = ((state_q == IDLE) && start_i && !flush_i) || busy_o;
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver queues expected results, monitor checks on done_o.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] result_o;

  muldiv_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  int          txn = 0;
  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];
  logic [31:0] mon_res;
  int          mon_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o with result 0x%08h, expected none (cycle %0d)",
                 result_o, cyc);
      end else begin
        mon_res = exp_res_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        chk("result", result_o, mon_res);
        chk("done_cycle", 32'(cyc), 32'(mon_cyc));
        txn++;
        $display("txn %0d: result=0x%08h expected=0x%08h cycle=%0d", txn, result_o, mon_res, cyc);
      end
    end
  end

  // Issues one op, holds start_i until (and through) DONE, checking stall_o every cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    bit seen;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = f3;
    rs1_i    = a;
    rs2_i    = b;
    exp_res_q.push_back(exp);
    exp_cyc_q.push_back(cyc + lat);
    #1 chk("stall_accept", {31'b0, stall_o}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < lat + 5 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_o) begin
        seen = 1'b1;
        chk("stall_done", {31'b0, stall_o}, 32'd0);
      end else begin
        chk("stall_busy", {31'b0, stall_o}, 32'd1);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done_o, expected one within %0d cycles", lat + 5);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_done", {31'b0, done_o}, 32'd0);
    chk("reset_stall", {31'b0, stall_o}, 32'd0);
    chk("reset_result", result_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op(3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op(3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op(3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op(3'b101, 32'd100,      32'd7,        32'd14,       33);
    @(negedge clk);
    start_i = 1'b0;

    // Flush ten cycles into a MUL: no write-back, old result stays.
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = 3'b000;
    rs1_i    = 32'd3;
    rs2_i    = 32'd5;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_busy", {31'b0, busy_o}, 32'd0);
    chk("flush_result", result_o, 32'd14);
    repeat (40) @(negedge clk);
    chk("flush_result_hold", result_o, 32'd14);
    run_op(3'b000, 32'd3, 32'd5, 32'd15, 33);
    @(negedge clk);
    start_i = 1'b0;

    // Reset five cycles into a DIV: outputs clear at once, no done_o afterwards.
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = 3'b100;
    rs1_i    = 32'd100;
    rs2_i    = 32'd7;
    repeat (5) @(negedge clk);
    rst_n   = 1'b0;
    start_i = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_result", result_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_result_hold", result_o, 32'h0);

    chk("pending_expectations", 32'(exp_res_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
